// File: rtl/uart_ns_tx.sv
// Transmitter for the ns UART: a small byte FIFO feeding a start/data/stop serialiser.
// Frames are back-to-back whenever the FIFO still holds data at the last stop cycle.
module uart_ns_tx #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic                          stop2_i,
   input  logic [DATA_W-1:0]             tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          tx_pin_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = DIV_W + 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              stop2_q, stop2_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              pin_q, pin_d;

   logic              push, pop, fifo_empty, bit_end;
   logic [TMR_W-1:0]  bit_len, stop_len;

   assign tx_ready_o   = (count_q != CNT_W'(FIFO_DEPTH));
   assign fifo_empty   = (count_q == '0);
   assign push         = tx_valid_i && tx_ready_o;
   assign busy_o       = (state_q != S_IDLE) || !fifo_empty;
   assign fifo_count_o = count_q;
   assign tx_pin_o     = pin_q;

   // A timer value of 0 or 1 ends the bit, so a divisor of 0 behaves like 1.
   assign bit_end  = (tmr_q <= TMR_W'(1));
   assign bit_len  = {1'b0, div_q};
   assign stop_len = !stop2_q         ? bit_len :
                     (div_q == '0)    ? TMR_W'(2) : {div_q, 1'b0};

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      stop2_d = stop2_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) pop = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
               tmr_d   = bit_len;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_STOP;
                  tmr_d   = stop_len;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  tmr_d = bit_len;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) pop = 1'b1;
               else             state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
      endcase
      // Frame start: divisor and stop mode are frozen here for the whole frame.
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
         div_d   = baud_div_i;
         stop2_d = stop2_i;
         tmr_d   = {1'b0, baud_div_i};
         state_d = S_START;
      end
      pin_d = (state_d == S_START) ? 1'b0 :
              (state_d == S_DATA)  ? shift_d[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         div_q   <= '0;
         stop2_q <= 1'b0;
         tmr_q   <= '0;
         idx_q   <= '0;
         pin_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         stop2_q <= stop2_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         pin_q   <= pin_d;
      end
   end

endmodule

// File: tb/tb_uart_ns_tx.sv
// Directed bench for uart_ns_tx: cycle-exact line checks plus a serial receiver
// whose decoded bytes are compared against an expected queue.
module tb_uart_ns_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] baud_div_i;
   logic        stop2_i;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic        tx_pin_o;
   logic        busy_o;
   logic [3:0]  fifo_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_div = 4;
   int         rx_ferr = 0;

   uart_ns_tx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .baud_div_i   (baud_div_i),
      .stop2_i      (stop2_i),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .tx_pin_o     (tx_pin_o),
      .busy_o       (busy_o),
      .fifo_count_o (fifo_count_o)
   );

   always #5 clk = ~clk;

   // Serial receiver: samples each bit at its middle using rx_div cycles per bit.
   initial begin
      bit         rx_busy;
      int         rx_cyc;
      int         k;
      logic [7:0] rx_sh;
      rx_busy = 1'b0;
      rx_cyc  = 0;
      rx_sh   = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            rx_busy = 1'b0;
         end else if (!rx_busy) begin
            if (tx_pin_o === 1'b0) begin
               rx_busy = 1'b1;
               rx_cyc  = 0;
            end
         end else begin
            rx_cyc++;
            if (rx_cyc % rx_div == rx_div / 2) begin
               k = rx_cyc / rx_div;
               if (k >= 1 && k <= 8) rx_sh[k-1] = tx_pin_o;
               if (k >= 9) begin
                  if (tx_pin_o !== 1'b1) rx_ferr++;
                  rx_q.push_back(rx_sh);
                  rx_busy = 1'b0;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      chk("push_ready", 32'(tx_ready_o), 32'd1);
      tx_data_i  = d;
      tx_valid_i = 1'b1;
      exp_q.push_back(d);
      @(negedge clk);
      tx_valid_i = 1'b0;
   endtask

   task automatic wait_start(input int limit);
      int n = 0;
      while (tx_pin_o !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", 32'(tx_pin_o), 32'd0);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy_o !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drained", 32'(busy_o), 32'd0);
   endtask

   // Entered on the negedge of frame cycle 'skip'; leaves on the negedge after the frame.
   task automatic check_frame(input logic [7:0] d, input int div, input bit st2, input int skip);
      int eff   = (div == 0) ? 1 : div;
      int total = 10 * eff + (st2 ? eff : 0);
      for (int c = skip; c < total; c++) begin
         int   b;
         logic e;
         b = c / eff;
         if (b == 0)      e = 1'b0;
         else if (b <= 8) e = d[b-1];
         else             e = 1'b1;
         chk($sformatf("frame_%02h_cyc%0d", d, c), 32'(tx_pin_o), 32'(e));
         @(negedge clk);
      end
   endtask

   task automatic check_rx(input string tag);
      chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      while (rx_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_rx_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int  stall_at;
      int  waited;
      bit  saw_low;

      rst_n      = 1'b0;
      baud_div_i = 16'd4;
      stop2_i    = 1'b0;
      tx_data_i  = '0;
      tx_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pin",   32'(tx_pin_o),     32'd1);
      chk("rst_ready", 32'(tx_ready_o),   32'd1);
      chk("rst_busy",  32'(busy_o),       32'd0);
      chk("rst_count", 32'(fifo_count_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte 0xA5 at 4 cycles per bit
      rx_div = 4;
      push_byte(8'hA5);
      chk("t1_count", 32'(fifo_count_o), 32'd1);
      chk("t1_busy",  32'(busy_o),       32'd1);
      chk("t1_idle",  32'(tx_pin_o),     32'd1);
      @(negedge clk);
      check_frame(8'hA5, 4, 1'b0, 0);
      chk("t1_busy_end", 32'(busy_o),       32'd0);
      chk("t1_pin_end",  32'(tx_pin_o),     32'd1);
      chk("t1_cnt_end",  32'(fifo_count_o), 32'd0);
      check_rx("t1");

      // Back-to-back 0x00, 0xFF, 0x55 at divisor 2
      baud_div_i = 16'd2;
      rx_div     = 2;
      tx_data_i  = 8'h00;
      tx_valid_i = 1'b1;
      exp_q.push_back(8'h00);
      @(negedge clk);
      chk("t2_idle", 32'(tx_pin_o), 32'd1);
      tx_data_i = 8'hFF;
      exp_q.push_back(8'hFF);
      @(negedge clk);
      chk("t2_cnt1",  32'(fifo_count_o), 32'd1);
      chk("t2_start", 32'(tx_pin_o),     32'd0);
      tx_data_i = 8'h55;
      exp_q.push_back(8'h55);
      @(negedge clk);
      tx_valid_i = 1'b0;
      chk("t2_cnt_peak", 32'(fifo_count_o), 32'd2);
      check_frame(8'h00, 2, 1'b0, 1);
      check_frame(8'hFF, 2, 1'b0, 0);
      check_frame(8'h55, 2, 1'b0, 0);
      chk("t2_busy_end", 32'(busy_o), 32'd0);
      check_rx("t2");

      // FIFO full: 10 bytes at divisor 16
      baud_div_i = 16'd16;
      rx_div     = 16;
      stall_at   = -1;
      for (int i = 0; i < 10; i++) begin
         tx_data_i  = 8'(i + 1);
         tx_valid_i = 1'b1;
         waited     = 0;
         while (tx_ready_o !== 1'b1 && waited < 400) begin
            if (stall_at < 0) begin
               stall_at = i;
               chk("t3_full_count", 32'(fifo_count_o), 32'd8);
            end
            @(negedge clk);
            waited++;
         end
         chk("t3_accept", 32'(tx_ready_o), 32'd1);
         exp_q.push_back(8'(i + 1));
         @(negedge clk);
      end
      tx_valid_i = 1'b0;
      chk("t3_stall_index", 32'(stall_at), 32'd9);
      wait_idle(3000);
      check_rx("t3");

      // Two stop bits at divisor 3, settings changed mid-frame
      stop2_i    = 1'b1;
      baud_div_i = 16'd3;
      rx_div     = 3;
      push_byte(8'h3C);
      wait_start(5);
      baud_div_i = 16'd8;
      stop2_i    = 1'b0;
      check_frame(8'h3C, 3, 1'b1, 0);
      chk("t4_busy_end", 32'(busy_o), 32'd0);
      check_rx("t4a");
      rx_div = 8;
      push_byte(8'h96);
      wait_start(5);
      check_frame(8'h96, 8, 1'b0, 0);
      chk("t4b_busy_end", 32'(busy_o), 32'd0);
      check_rx("t4b");

      // Minimum divisors 1 and 0
      baud_div_i = 16'd1;
      rx_div     = 1;
      push_byte(8'h81);
      wait_start(5);
      check_frame(8'h81, 1, 1'b0, 0);
      chk("t5a_busy_end", 32'(busy_o), 32'd0);
      baud_div_i = 16'd0;
      push_byte(8'h81);
      wait_start(5);
      check_frame(8'h81, 0, 1'b0, 0);
      chk("t5b_busy_end", 32'(busy_o), 32'd0);
      check_rx("t5");

      // Reset during the DATA state of the first of three frames
      baud_div_i = 16'd8;
      rx_div     = 8;
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      repeat (20) @(negedge clk);
      chk("t6_busy_pre",  32'(busy_o),       32'd1);
      chk("t6_count_pre", 32'(fifo_count_o), 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_pin",   32'(tx_pin_o),     32'd1);
      chk("t6_count", 32'(fifo_count_o), 32'd0);
      chk("t6_busy",  32'(busy_o),       32'd0);
      chk("t6_ready", 32'(tx_ready_o),   32'd1);
      rst_n = 1'b1;
      exp_q.delete();
      saw_low = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (tx_pin_o !== 1'b1) saw_low = 1'b1;
      end
      chk("t6_no_frames", 32'(saw_low), 32'd0);
      chk("t6_busy_end",  32'(busy_o),  32'd0);
      check_rx("t6");

      chk("framing_errors", 32'(rx_ferr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
